// File: rtl/process_scheduler.sv
// Round-robin time-sliced process scheduler: process table, quantum counter, context-switch handshake.
// Optional statistics counter built when SCHED_STATS_EN is defined.
module process_scheduler #(
    parameter int NPROC    = 4,
    parameter int QUANTUM  = 16,
    parameter int OFFSET_W = 12,
    parameter int IDX_W    = 2
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                enable,
    input  logic                instr_retire,
    input  logic                halt_in,
    input  logic                io_wait,
    input  logic                ctx_ack,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic                cfg_valid,
    input  logic [OFFSET_W-1:0] cfg_offset,
    output logic                ctx_switch_req,
    output logic                offset_change,
    output logic [OFFSET_W-1:0] ram_offset,
    output logic [IDX_W-1:0]    cur_proc,
    output logic                running,
    output logic [15:0]         switch_count
);

    localparam int CNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(QUANTUM - 1);

    typedef enum logic [2:0] {IDLE, SELECT, LOAD, RUN, SAVE} state_t;

    state_t               state, state_nxt;
    logic [NPROC-1:0]     valid_tab;
    logic [OFFSET_W-1:0]  offset_tab [NPROC];
    logic [CNT_W-1:0]     quantum_cnt;
    logic                 found;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W-1:0]     scan_idx;
    logic                 retire_ok;
    logic                 expiry;
    logic                 halt_eff;
    logic                 halt_clear;

    // Scan order cur_proc+1 .. cur_proc+NPROC; the last step wraps back onto cur_proc.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = '0;
        for (int unsigned i = 1; i <= NPROC; i++) begin
            scan_idx = cur_proc + IDX_W'(i);
            if (!found && valid_tab[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    assign retire_ok  = instr_retire && !io_wait;
    assign expiry     = retire_ok && (quantum_cnt == '0);
    // A running slot invalidated through the config port behaves like a halt one cycle later.
    assign halt_eff   = halt_in || !valid_tab[cur_proc];
    assign halt_clear = (state == RUN) && halt_in;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && (|valid_tab)) state_nxt = SELECT;
            SELECT:  state_nxt = found ? LOAD : IDLE;
            LOAD:    state_nxt = RUN;
            RUN:     if (halt_eff || !enable || expiry) state_nxt = SAVE;
            SAVE:    if (ctx_ack) state_nxt = enable ? SELECT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        running        = (state == RUN);
        ctx_switch_req = (state == SAVE);
        offset_change  = (state == LOAD);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            valid_tab   <= '0;
            cur_proc    <= '0;
            ram_offset  <= '0;
            quantum_cnt <= '0;
            for (int unsigned i = 0; i < NPROC; i++) offset_tab[i] <= '0;
        end else begin
            state <= state_nxt;

            // Config write is issued after the halt clear so it wins on the same slot.
            if (halt_clear) valid_tab[cur_proc] <= 1'b0;
            if (cfg_we) begin
                valid_tab[cfg_idx]  <= cfg_valid;
                offset_tab[cfg_idx] <= cfg_offset;
            end

            // New slot becomes visible during LOAD, together with the offset_change pulse.
            if (state == SELECT && found) begin
                cur_proc   <= pick;
                ram_offset <= offset_tab[pick];
            end

            if (state == LOAD)
                quantum_cnt <= CNT_LOAD;
            else if (state == RUN && retire_ok && quantum_cnt != '0)
                quantum_cnt <= quantum_cnt - 1'b1;
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge CLK) begin
        if (reset)
            switch_count <= '0;
        else if (state == SELECT && found && switch_count != '1)
            switch_count <= switch_count + 16'd1;
    end
`else
    assign switch_count = '0;
`endif

endmodule

// File: tb/tb_process_scheduler.sv
// Directed self-checking bench for process_scheduler (default parameters, QUANTUM=16).
module tb_process_scheduler;

    logic        CLK = 1'b0;
    logic        reset, enable, instr_retire, halt_in, io_wait, ctx_ack;
    logic        cfg_we, cfg_valid;
    logic [1:0]  cfg_idx;
    logic [11:0] cfg_offset;
    logic        ctx_switch_req, offset_change, running;
    logic [11:0] ram_offset;
    logic [1:0]  cur_proc;
    logic [15:0] switch_count;

    int checks   = 0;
    int failures = 0;

    process_scheduler #(.NPROC(4), .QUANTUM(16), .OFFSET_W(12), .IDX_W(2)) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .instr_retire(instr_retire),
        .halt_in(halt_in), .io_wait(io_wait), .ctx_ack(ctx_ack), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_offset(cfg_offset),
        .ctx_switch_req(ctx_switch_req), .offset_change(offset_change),
        .ram_offset(ram_offset), .cur_proc(cur_proc), .running(running),
        .switch_count(switch_count)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_sc(input int n);
`ifdef SCHED_STATS_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic cfg_write(input logic [1:0] idx, input logic v, input logic [11:0] off);
        cfg_we = 1'b1; cfg_idx = idx; cfg_valid = v; cfg_offset = off;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_load(input string tag, input logic [1:0] p, input logic [11:0] off);
        int n;
        n = 0;
        while (!offset_change && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, offset_change, 1);
        chk({tag, "_proc"}, cur_proc, p);
        chk({tag, "_off"}, ram_offset, off);
        tick();
        chk({tag, "_pulse1"}, offset_change, 0);
        chk({tag, "_run"}, running, 1);
    endtask

    task automatic run_out(input string tag);
        int n;
        n = 0;
        while (running && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_slice"}, n, 16);
        chk({tag, "_req"}, ctx_switch_req, 1);
    endtask

    task automatic ack(input string tag);
        ctx_ack = 1'b1;
        tick();
        ctx_ack = 1'b0;
        chk({tag, "_reqdrop"}, ctx_switch_req, 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; instr_retire = 1'b0; halt_in = 1'b0;
        io_wait = 1'b0; ctx_ack = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_valid = 1'b0; cfg_offset = '0;
        tick(); tick();
        chk("rst_running", running, 0);
        chk("rst_req", ctx_switch_req, 0);
        chk("rst_oc", offset_change, 0);
        chk("rst_off", ram_offset, 0);
        chk("rst_proc", cur_proc, 0);
        chk("rst_sc", switch_count, 0);
        reset = 1'b0;

        // Round robin over four slots
        cfg_write(2'd0, 1'b1, 12'h000);
        cfg_write(2'd1, 1'b1, 12'h100);
        cfg_write(2'd2, 1'b1, 12'h200);
        cfg_write(2'd3, 1'b1, 12'h300);
        chk("idle_disabled", running, 0);
        enable = 1'b1; instr_retire = 1'b1;
        wait_load("rr1", 2'd1, 12'h100); run_out("rr1"); ack("rr1");
        wait_load("rr2", 2'd2, 12'h200); run_out("rr2"); ack("rr2");
        wait_load("rr3", 2'd3, 12'h300); run_out("rr3"); ack("rr3");
        wait_load("rr0", 2'd0, 12'h000); run_out("rr0"); ack("rr0");
        wait_load("rr1b", 2'd1, 12'h100); run_out("rr1b"); ack("rr1b");

        // Halt of slot 2, delayed ack
        wait_load("h2", 2'd2, 12'h200);
        tick(); tick(); tick();
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        chk("halt_req", ctx_switch_req, 1);
        chk("halt_notrun", running, 0);
        repeat (5) tick();
        chk("halt_req_held", ctx_switch_req, 1);
        ack("halt");
        wait_load("h3", 2'd3, 12'h300); run_out("h3"); ack("h3");
        wait_load("h0", 2'd0, 12'h000); run_out("h0"); ack("h0");
        wait_load("h1", 2'd1, 12'h100); run_out("h1"); ack("h1");

        // io_wait freezes the quantum at 3
        wait_load("io", 2'd3, 12'h300);
        repeat (12) tick();
        io_wait = 1'b1;
        repeat (20) tick();
        chk("io_frozen_run", running, 1);
        chk("io_frozen_req", ctx_switch_req, 0);
        io_wait = 1'b0;
        repeat (3) tick();
        chk("io_3retire_run", running, 1);
        tick();
        chk("io_4retire_req", ctx_switch_req, 1);
        ack("io");
        wait_load("io_next", 2'd0, 12'h000);

        // Single valid slot re-selected, then cleared via config
        reset = 1'b1; tick(); reset = 1'b0;
        enable = 1'b0;
        cfg_write(2'd1, 1'b1, 12'h100);
        enable = 1'b1;
        wait_load("s1a", 2'd1, 12'h100); run_out("s1a"); ack("s1a");
        wait_load("s1b", 2'd1, 12'h100);
        cfg_write(2'd1, 1'b0, 12'h100);
        tick();
        chk("clr_req", ctx_switch_req, 1);
        ack("clr");
        tick();
        chk("clr_idle_run", running, 0);
        chk("clr_idle_oc", offset_change, 0);
        chk("clr_hold_off", ram_offset, 12'h100);
        chk("clr_hold_proc", cur_proc, 1);

        // Halt + expiry + config re-validate in the same cycle
        cfg_write(2'd1, 1'b1, 12'h100);
        wait_load("hx", 2'd1, 12'h100);
        repeat (15) tick();
        chk("hx_pre_run", running, 1);
        halt_in = 1'b1;
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_valid = 1'b1; cfg_offset = 12'h180;
        tick();
        halt_in = 1'b0; cfg_we = 1'b0;
        chk("hx_req", ctx_switch_req, 1);
        ack("hx");
        wait_load("hx_reload", 2'd1, 12'h180);
        chk("hx_sc", switch_count, exp_sc(4));
        run_out("hx");

        // Reset while a switch request is pending
        reset = 1'b1;
        tick();
        chk("rs_req", ctx_switch_req, 0);
        chk("rs_run", running, 0);
        chk("rs_off", ram_offset, 0);
        chk("rs_proc", cur_proc, 0);
        chk("rs_sc", switch_count, 0);
        reset = 1'b0;
        repeat (3) tick();
        chk("rs_table_empty", running, 0);
        chk("rs_no_load", offset_change, 0);

        enable = 1'b0;
        cfg_write(2'd0, 1'b1, 12'h040);
        cfg_write(2'd1, 1'b1, 12'h0C0);
        enable = 1'b1;
        wait_load("c1", 2'd1, 12'h0C0); run_out("c1"); ack("c1");
        wait_load("c2", 2'd0, 12'h040); run_out("c2"); ack("c2");
        wait_load("c3", 2'd1, 12'h0C0); run_out("c3"); ack("c3");
        wait_load("c4", 2'd0, 12'h040); run_out("c4"); ack("c4");
        wait_load("c5", 2'd1, 12'h0C0);
        chk("count5", switch_count, exp_sc(5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
